fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decoder/CU: owns the PC, issues word fetches to instruction memory,

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset vector, NOP encoding, FSM states, buffer entry layout
// and the RV32I major opcodes that the control unit decodes from id_instr[6:0].
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parametric synchronous FIFO with flush and occupancy count; head data is read combinationally.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count guarantees no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem request/response tracking, instruction buffer, redirects.
// Optional: define FETCH_MISALIGN_CHK_EN to flag misaligned redirect targets via fetch_fault.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] kill_q, kill_d;
  logic          fault_q, fault_d;

  logic [CW-1:0] data_count, tag_count;
  logic [31:0]   tag_head;
  fetch_entry_t  push_entry, head;
  logic [CW:0]   in_use;
  logic          issue, resp_live, resp_drop, resp_tracked, id_xfer;
  logic          misalign, take_target;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign take_target = redirect && !misalign;

  // Outstanding requests include wrong-path ones still in flight, so the buffer can never overflow.
  assign in_use    = {1'b0, outst_q} + {1'b0, data_count};
  assign imem_req  = (state_q == ST_RUN) && !halt && !redirect && !fault_q && (in_use < DEPTH_W);
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;

  // Responses with no tag pending belong to requests issued before reset and are ignored.
  assign resp_tracked = imem_rvalid && (outst_q != '0);
  assign resp_drop    = imem_rvalid && (kill_q != '0);
  assign resp_live    = imem_rvalid && (kill_q == '0) && (tag_count != '0);

  assign id_valid = (data_count != '0);
  assign id_xfer  = id_valid && id_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    fault_d = fault_q || misalign;
    outst_d = outst_q + CW'(issue) - CW'(resp_tracked);

    if (issue)     pc_d   = pc_q + 32'd4;
    if (resp_drop) kill_d = kill_q - CW'(1);

    unique case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_HALTED;
      ST_HALTED: if (!halt || redirect) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase

    if (take_target) pc_d = redirect_pc & ~32'd3;
    if (redirect)    kill_d = outst_d;
    if (misalign)    state_d = ST_HALTED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      kill_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
      fault_q <= fault_d;
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (pc_q),
    .pop       (resp_live),
    .flush     (redirect),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  assign push_entry = '{instr: imem_rdata, pc: tag_head};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_live),
    .push_data (push_entry),
    .pop       (id_xfer),
    .flush     (redirect),
    .pop_data  (head),
    .count     (data_count)
  );

  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc       = head.pc;
  assign id_pc4      = pc_plus4(head.pc);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized imem grant/latency, decode backpressure, redirects
// and halt, compared against an epoch-based transaction model of the instruction stream.
module tb_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, halt;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready, fetch_fault;
  logic [31:0] id_instr, id_pc, id_pc4;

  logic        w_req, w_rvalid, w_valid, w_fault;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc4(id_pc4), .fetch_fault(fetch_fault)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_gnt(1'b1), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0), .halt(1'b0),
    .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_instr),
    .id_pc(w_pc), .id_pc4(w_pc4), .fetch_fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } imem_txn_t;

  imem_txn_t   iq[$];
  int          vectors, miscompares;
  int          cyc, epoch, pending, fifo_exp;
  int          lat_min, lat_max, gnt_pct, ready_pct;
  logic [31:0] exp_issue_pc, exp_id_pc, first_xfer_pc;
  logic [31:0] w_exp_issue, w_exp_id, w_last_addr;
  bit          prev_halt, boot_done, xfer_seen, exp_fault, w_iss;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model of one clock cycle, evaluated mid-cycle while inputs and outputs are stable.
  task automatic observe();
    imem_txn_t t;
    check("id_valid", 32'(id_valid), 32'(fifo_exp > 0));
    check("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
    if (!boot_done)
      check("boot_req", 32'(imem_req), 32'd0);
    else if (halt || redirect || exp_fault || pending >= DEPTH)
      check("req_blocked", 32'(imem_req), 32'd0);
    else if (!prev_halt)
      check("req_issue", 32'(imem_req), 32'd1);

    if (id_valid && id_ready) begin
      check("id_pc", id_pc, exp_id_pc);
      check("id_instr", id_instr, instr_of(exp_id_pc));
      check("id_pc4", id_pc4, exp_id_pc + 32'd4);
      if (!xfer_seen) begin
        xfer_seen     = 1'b1;
        first_xfer_pc = id_pc;
      end
      exp_id_pc += 32'd4;
      fifo_exp--;
      pending--;
    end

    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, exp_issue_pc);
      t.addr  = exp_issue_pc;
      t.epoch = epoch;
      t.due   = cyc + int'($urandom_range(lat_max, lat_min));
      iq.push_back(t);
      exp_issue_pc += 32'd4;
      pending++;
    end

    if (imem_rvalid) begin
      t = iq.pop_front();
      if (t.epoch == epoch) fifo_exp++;
      else pending--;
    end

    if (redirect) begin
      epoch++;
      fifo_exp = 0;
      pending  = iq.size();
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        exp_fault = 1'b1;
      end else begin
        exp_issue_pc = redirect_pc & ~32'd3;
        exp_id_pc    = exp_issue_pc;
      end
`else
      exp_issue_pc = redirect_pc & ~32'd3;
      exp_id_pc    = exp_issue_pc;
`endif
    end

    w_iss = w_req;
    if (w_req) begin
      check("wrap_addr", w_addr, w_exp_issue);
      w_last_addr = w_exp_issue;
      w_exp_issue += 32'd4;
    end
    if (w_valid) begin
      check("wrap_pc", w_pc, w_exp_id);
      check("wrap_instr", w_instr, instr_of(w_exp_id));
      w_exp_id += 32'd4;
    end
    check("wrap_fault", 32'(w_fault), 32'd0);

    prev_halt = halt;
    boot_done = 1'b1;
  endtask

  task automatic drive();
    imem_gnt = (int'($urandom_range(99)) < gnt_pct);
    id_ready = (int'($urandom_range(99)) < ready_pct);
    redirect = 1'b0;
    if (iq.size() > 0 && iq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(iq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    w_rvalid = w_iss;
    w_rdata  = instr_of(w_last_addr);
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  // Steps through the redirect cycle, then waits for the first transfer of the new path.
  task automatic expect_first_xfer(input string tag, input logic [31:0] exp);
    bit got;
    step();
    xfer_seen = 1'b0;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = xfer_seen;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) check(tag, first_xfer_pc, exp);
  endtask

  initial begin : main
    bit ok;
    int n;
    vectors = 0; miscompares = 0; cyc = 0; epoch = 0; pending = 0; fifo_exp = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100; ready_pct = 100;
    exp_issue_pc = 32'h0; exp_id_pc = 32'h0; first_xfer_pc = 32'h0;
    w_exp_issue = WRAP_PC; w_exp_id = WRAP_PC; w_last_addr = 32'h0;
    prev_halt = 1'b0; boot_done = 1'b0; xfer_seen = 1'b0; exp_fault = 1'b0; w_iss = 1'b0;
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; id_ready = 1'b0;
    w_rvalid = 1'b0; w_rdata = 32'h0;

    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_wrap_req", 32'(w_req), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();

    // Streaming with a 1-cycle memory and an always-ready decoder.
    repeat (30) step();

    // Decoder backpressure: the buffer and outstanding requests fill up, then issue stops.
    ready_pct = 0;
    repeat (10) step();
    check("stall_pending", 32'(pending), 32'(DEPTH));
    check("stall_req", 32'(imem_req), 32'd0);
    ready_pct = 100;
    repeat (10) step();

    // Redirect with two requests in flight; their responses must be discarded.
    lat_min = 4; lat_max = 4;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      ok = (iq.size() == 2 && fifo_exp == 0);
    end
    check("redir_setup", 32'(ok), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h100;
    lat_min = 1; lat_max = 1;
    expect_first_xfer("redir_pc", 32'h100);

    // Redirect-to-valid latency with nothing outstanding.
    gnt_pct = 0;
    repeat (6) step();
    gnt_pct = 100;
    redirect = 1'b1; redirect_pc = 32'h180;
    step();
    n = 1;
    while (!id_valid && n < 20) begin
      step();
      n++;
    end
    check("redir_latency", 32'(n), 32'd3);

    // Halt: issue stops and the buffer drains; a redirect resumes fetching.
    lat_max = 3;
    halt = 1'b1;
    repeat (15) step();
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_drained", 32'(id_valid), 32'd0);
    halt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h200;
    expect_first_xfer("halt_redir_pc", 32'h200);

    // Randomized traffic with occasional redirects and halt toggles.
    gnt_pct = 70; ready_pct = 60;
    for (int i = 0; i < 800; i++) begin
      step();
      if ($urandom_range(99) < 3) begin
        redirect    = 1'b1;
        redirect_pc = $urandom & ~32'd3;
      end
      if ($urandom_range(99) < 2) halt = ~halt;
    end
    halt = 1'b0;
    repeat (6) step();

    // Misaligned redirect target.
    gnt_pct = 100; ready_pct = 100; lat_max = 1;
    redirect = 1'b1; redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHK_EN
    repeat (10) step();
    check("misalign_fault", 32'(fetch_fault), 32'd1);
    check("misalign_req", 32'(imem_req), 32'd0);
`else
    expect_first_xfer("misalign_pc", 32'h100);
`endif
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
